// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state
// encoding, owner encoding and the legal memory-latency range.
package mem_arb_pkg;

  // Arbiter FSM states; the WAIT states also identify the owner.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_DM = 2'd2
  } arb_state_e;

  // Owner of the outstanding transaction.
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  // Supported memory read latency, in cycles from issue to read data.
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;

  function automatic bit mem_lat_legal(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

  // WAIT state that tracks a transaction issued for the given owner.
  function automatic arb_state_e wait_state(input logic owner);
    return (owner == OWNER_DM) ? WAIT_DM : WAIT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Down-counter that tracks a fixed access latency. Loaded with the
// latency at issue, it counts down once per cycle and flags the final
// cycle of the access (count == 1). Also intended for the cache-fill
// sequencer, so it carries no arbiter-specific knowledge.
module lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         done
);

  // Load on issue, otherwise count down to zero and stay there.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // The final cycle of an access is the one where one cycle remains.
  assign done = (count == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port unified instruction/data memory. Fetch and
// the load/store unit compete for one transaction at a time; data wins by
// default, but fetch is forced through after STARVE_MAX consecutive data
// grants while it waits. Read data returns to the owner a fixed MEM_LAT
// cycles after the grant, and a new transaction may issue in that same
// cycle so the port sustains one access per MEM_LAT cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  // fetch stage
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // load/store unit
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // pipeline control
  output logic              fetch_stall
);

  localparam int LAT_W    = $clog2(MEM_LAT + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  localparam logic [LAT_W-1:0]    LAT_LOAD     = LAT_W'(MEM_LAT);
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

  // Reject latencies the issue/complete overlap was not built for.
  if (!mem_lat_legal(MEM_LAT)) begin : g_mem_lat_illegal
    $error("mem_port_arbiter: MEM_LAT must lie in 1..3");
  end

  arb_state_e          state_q;
  arb_state_e          state_d;
  logic [LAT_W-1:0]    lat_cnt;
  logic                lat_done;
  logic [STARVE_W-1:0] starve_cnt;
  logic                in_wait;
  logic                owner;
  logic                can_issue;
  logic                fetch_wins;
  logic                issue_if;
  logic                issue_dm;
  logic                complete;

  // ------------------------------------------------------------------
  // Issue and priority
  // ------------------------------------------------------------------
  assign in_wait = (state_q != IDLE);
  assign owner   = (state_q == WAIT_DM) ? OWNER_DM : OWNER_IF;

  // Issue from IDLE, or in the final WAIT cycle to overlap the next access
  // with the current completion. Nothing issues while reset is held.
  assign can_issue = ~reset & (~in_wait | lat_done);

  // Data wins unless fetch has been passed over STARVE_MAX times in a row.
  assign fetch_wins = if_req & (~dm_req | (starve_cnt == STARVE_LIMIT));

  assign issue_if = can_issue & fetch_wins;
  assign issue_dm = can_issue & dm_req & ~fetch_wins;

  assign if_gnt = issue_if;
  assign dm_gnt = issue_dm;

  // Drive the memory port for whichever requester was granted this cycle.
  // NOTE: every output of a combinational block gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue_if) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (issue_dm) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
  end

  // ------------------------------------------------------------------
  // Latency tracking and completion
  // ------------------------------------------------------------------
  lat_counter #(
    .W (LAT_W)
  ) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (issue_if | issue_dm),
    .load_val (LAT_LOAD),
    .count    (lat_cnt),
    .done     (lat_done)
  );

  // The final WAIT cycle carries the read data; reset abandons it.
  assign complete  = ~reset & in_wait & lat_done;
  assign if_rvalid = complete & (owner == OWNER_IF);
  assign dm_rvalid = complete & (owner == OWNER_DM);

  // Read data is only presented to the owner, and only while valid.
  assign if_rdata = if_rvalid ? mem_rdata : '0;
  assign dm_rdata = dm_rvalid ? mem_rdata : '0;

  // Hold the PC while fetch wants the memory and has not got its data.
  assign fetch_stall = if_req & ~if_rvalid;

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  // Next state: a new issue picks the matching WAIT state; a completion
  // with nothing to issue returns to IDLE; otherwise hold.
  always_comb begin
    state_d = state_q;
    if (issue_if | issue_dm) begin
      state_d = wait_state(issue_dm ? OWNER_DM : OWNER_IF);
    end else if (in_wait & lat_done) begin
      state_d = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Count data grants that pass over a waiting fetch; saturate at the
  // limit, and clear on a fetch grant or whenever fetch is not waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (issue_if | ~if_req) begin
      starve_cnt <= '0;
    end else if (issue_dm && (starve_cnt != STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // ------------------------------------------------------------------
  // Structural invariants
  // ------------------------------------------------------------------
  a_we_implies_en : assert property (
    @(posedge clk) disable iff (reset) mem_we |-> mem_en);

  a_one_grant : assert property (
    @(posedge clk) disable iff (reset) !(if_gnt && dm_gnt));

  a_one_rvalid : assert property (
    @(posedge clk) disable iff (reset) !(if_rvalid && dm_rvalid));

endmodule
